// File: rtl/neuron_pkg.sv
// neuron_pkg: shared constants, sequencer state type and the W-bit accumulate helper.
// Build option: define NEURON_SAT_EN to make every accumulate saturate instead of wrap.
package neuron_pkg;

    localparam int unsigned W_DEF           = 20;
    localparam int unsigned N_IN_DEF        = 9;
    localparam int unsigned ROWS_PER_NEURON = N_IN_DEF + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_e;

`ifdef NEURON_SAT_EN
    localparam logic signed [W_DEF-1:0] ACC_MAX = {1'b0, {(W_DEF-1){1'b1}}};
    localparam logic signed [W_DEF-1:0] ACC_MIN = {1'b1, {(W_DEF-1){1'b0}}};
`endif

    // Two's-complement add; clamps on signed overflow when saturation is built in.
    function automatic logic signed [W_DEF-1:0] sat_add(
        input logic signed [W_DEF-1:0] a,
        input logic signed [W_DEF-1:0] b
    );
        logic signed [W_DEF-1:0] sum;
        sum = a + b;
`ifdef NEURON_SAT_EN
        if ((a[W_DEF-1] == b[W_DEF-1]) && (sum[W_DEF-1] != a[W_DEF-1])) begin
            sum = a[W_DEF-1] ? ACC_MIN : ACC_MAX;
        end
`endif
        return sum;
    endfunction

endpackage

// File: rtl/neuron_acc.sv
// neuron_acc: registered W-bit accumulator with synchronous clear and a pixel-gated add.
// Build option: NEURON_SAT_EN (through sat_add) selects saturating accumulation.
module neuron_acc
    import neuron_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr,
    input  logic                    en,
    input  logic                    add_gate,
    input  logic signed [W_DEF-1:0] din,
    output logic signed [W_DEF-1:0] acc
);

    logic signed [W_DEF-1:0] acc_q;
    logic signed [W_DEF-1:0] acc_d;

    // Clear wins over add; an add happens only when enabled and its pixel is set.
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en && add_gate) begin
            acc_d = sat_add(acc_q, din);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;

endmodule

// File: rtl/neuron_seq.sv
// neuron_seq: evaluates N_NEURONS binary-pixel neurons serially on one accumulator,
// streaming weights/bias from a 1-cycle-latency ROM and emitting each result on valid/ready.
// Build option: NEURON_SAT_EN selects saturating accumulation (default wraps).
module neuron_seq
    import neuron_pkg::*;
#(
    parameter  int unsigned N_NEURONS = 4,
    parameter  int unsigned N_IN      = N_IN_DEF,
    // Datapath width is tied to the package accumulate helper.
    localparam int unsigned W         = W_DEF,
    localparam int unsigned AW        = $clog2(N_NEURONS * (N_IN + 1)),
    localparam int unsigned NW        = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [N_IN-1:0]     pix,
    output logic                busy,
    output logic                w_en,
    output logic [AW-1:0]       w_addr,
    input  logic signed [W-1:0] w_data,
    output logic                d_valid,
    input  logic                d_ready,
    output logic signed [W-1:0] d_out,
    output logic [NW-1:0]       d_idx,
    output logic                done
);

    // k walks 0..N_IN+1 inside RUN: N_IN+1 issue cycles then one bias-return cycle.
    localparam int unsigned KW     = $clog2(N_IN + 2);
    localparam logic [KW-1:0] K_LAST = KW'(N_IN + 1);
    localparam logic [KW-1:0] K_BIAS = KW'(N_IN);
    localparam logic [NW-1:0] N_LAST = NW'(N_NEURONS - 1);
    localparam logic [AW-1:0] ROWS_A = AW'(N_IN + 1);

    state_e               state_q, state_d;
    logic [KW-1:0]        k_q, k_d;
    logic [NW-1:0]        n_q, n_d;
    logic [N_IN-1:0]      pix_q, pix_d;

    logic                 w_en_q, w_en_d;
    logic [AW-1:0]        w_addr_q, w_addr_d;
    logic                 d_valid_q, d_valid_d;
    logic signed [W-1:0]  d_out_q, d_out_d;
    logic [NW-1:0]        d_idx_q, d_idx_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 hs;
    logic                 acc_clr;
    logic                 acc_en;
    logic                 pix_gate;
    logic signed [W-1:0]  acc;

    assign hs = d_valid_q && d_ready;

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            k_q       <= '0;
            n_q       <= '0;
            pix_q     <= '0;
            w_en_q    <= 1'b0;
            w_addr_q  <= '0;
            d_valid_q <= 1'b0;
            d_out_q   <= '0;
            d_idx_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            n_q       <= n_d;
            pix_q     <= pix_d;
            w_en_q    <= w_en_d;
            w_addr_q  <= w_addr_d;
            d_valid_q <= d_valid_d;
            d_out_q   <= d_out_d;
            d_idx_q   <= d_idx_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state: frame sequencing, step counter, neuron counter and pixel capture.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        n_d     = n_q;
        pix_d   = pix_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    k_d     = '0;
                    n_d     = '0;
                    pix_d   = pix;
                end
            end
            RUN: begin
                if (k_q == K_LAST) begin
                    state_d = EMIT;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            EMIT: begin
                if (hs) begin
                    if (n_q == N_LAST) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                        n_d     = n_q + NW'(1);
                        k_d     = '0;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Pixel select: data returning at step k is weight k-1, gated by pix[k-1].
    always_comb begin
        pix_gate = 1'b0;
        for (int unsigned i = 0; i < N_IN; i++) begin
            if (k_q == KW'(i + 1)) begin
                pix_gate = pix_q[i];
            end
        end
    end

    assign acc_clr = ((state_q == IDLE) && start) || hs;
    assign acc_en  = (state_q == RUN) && (k_q != '0) && (k_q != K_LAST);

    neuron_acc u_acc (
        .clk      (clk),
        .rst      (rst),
        .clr      (acc_clr),
        .en       (acc_en),
        .add_gate (pix_gate),
        .din      (w_data),
        .acc      (acc)
    );

    // Outputs: ROM issue for the coming step, result capture on the bias cycle, status flags.
    always_comb begin
        w_en_d    = (state_d == RUN) && (k_d <= K_BIAS);
        w_addr_d  = w_addr_q;
        d_out_d   = d_out_q;
        d_idx_d   = d_idx_q;
        d_valid_d = (state_d == EMIT);
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        if (w_en_d) begin
            w_addr_d = AW'(n_d) * ROWS_A + AW'(k_d);
        end
        if ((state_q == RUN) && (k_q == K_LAST)) begin
            d_out_d = sat_add(acc, w_data);
            d_idx_d = n_q;
        end
    end

    assign busy    = busy_q;
    assign w_en    = w_en_q;
    assign w_addr  = w_addr_q;
    assign d_valid = d_valid_q;
    assign d_out   = d_out_q;
    assign d_idx   = d_idx_q;
    assign done    = done_q;

endmodule
